// File: rtl/cpu_run_controller.sv
// cpu_run_controller
// Sequences one program run of the accumulator CPU. It loads the program
// image into instruction RAM while the CPU is held in reset, then releases
// reset on start. The run ends on HALT, abort or a cycle-budget timeout, and
// the controller latches ACC/PC and the outcome.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-low reset
//   load_valid/ready      byte-wide program load handshake
//   load_addr/data/last   target address, byte, final-byte marker
//   start, abort          run request (level) and run termination
//   cpu_halted/acc/pc     observed CPU state
//   cpu_rst               active-high CPU reset (low only while running)
//   imem_we/waddr/wdata   instruction RAM write port (one cycle after accept)
//   busy, done            busy in RST/RUN/DONE; done pulses for one cycle
//   status                00 none, 01 halted, 10 timeout, 11 aborted
//   result_acc/pc         ACC/PC captured at completion
//   cycle_count           RUN cycles elapsed in the current or last run
module cpu_run_controller #(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned RST_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 100,
    parameter int unsigned CNT_W          = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              start,
    input  logic              abort,
    input  logic              cpu_halted,
    input  logic [DATA_W-1:0] cpu_acc,
    input  logic [ADDR_W-1:0] cpu_pc,
    output logic              cpu_rst,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              busy,
    output logic              done,
    output logic [1:0]        status,
    output logic [DATA_W-1:0] result_acc,
    output logic [ADDR_W-1:0] result_pc,
    output logic [CNT_W-1:0]  cycle_count
);

    // Counter holds the remaining RST cycles minus one.
    localparam int unsigned RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RST  = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_HALTED  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_ABORTED = 2'b11;

    logic [2:0]        state, state_d;
    logic [RST_W-1:0]  rst_cnt, rst_cnt_d;
    logic [CNT_W-1:0]  cycle_count_d;
    logic [1:0]        status_d;
    logic [DATA_W-1:0] result_acc_d;
    logic [ADDR_W-1:0] result_pc_d;
    logic              ready_q, ready_d;
    logic              cpu_rst_d, busy_d, done_d;
    logic              accept;

    // Registered ready, masked while reset is held low.
    assign load_ready = ready_q & reset;
    assign accept     = load_valid & load_ready;

    // Next-state, run bookkeeping and decoded output values.
    always_comb begin
        state_d       = state;
        rst_cnt_d     = rst_cnt;
        cycle_count_d = cycle_count;
        status_d      = status;
        result_acc_d  = result_acc;
        result_pc_d   = result_pc;

        case (state)
            S_IDLE: begin
                // A byte offered together with start takes precedence.
                if (accept) begin
                    if (!load_last) begin
                        state_d = S_LOAD;
                    end
                end else if (start && !load_valid) begin
                    state_d       = S_RST;
                    rst_cnt_d     = RST_W'(RST_CYCLES - 1);
                    cycle_count_d = '0;
                    status_d      = ST_NONE;
                    result_acc_d  = '0;
                    result_pc_d   = '0;
                end
            end

            S_LOAD: begin
                if (accept && load_last) begin
                    state_d = S_IDLE;
                end
            end

            S_RST: begin
                if (abort) begin
                    state_d      = S_DONE;
                    status_d     = ST_ABORTED;
                    result_acc_d = '0;
                    result_pc_d  = '0;
                end else if (rst_cnt == '0) begin
                    state_d       = S_RUN;
                    cycle_count_d = CNT_W'(1);
                end else begin
                    rst_cnt_d = rst_cnt - RST_W'(1);
                end
            end

            S_RUN: begin
                // Halt outranks abort, which outranks the timeout.
                if (cpu_halted) begin
                    state_d      = S_DONE;
                    status_d     = ST_HALTED;
                    result_acc_d = cpu_acc;
                    result_pc_d  = cpu_pc;
                end else if (abort) begin
                    state_d      = S_DONE;
                    status_d     = ST_ABORTED;
                    result_acc_d = cpu_acc;
                    result_pc_d  = cpu_pc;
                end else if (cycle_count == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_d      = S_DONE;
                    status_d     = ST_TIMEOUT;
                    result_acc_d = cpu_acc;
                    result_pc_d  = cpu_pc;
                end else begin
                    cycle_count_d = cycle_count + CNT_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d   = (state_d == S_IDLE) || (state_d == S_LOAD);
        cpu_rst_d = (state_d != S_RUN);
        busy_d    = (state_d == S_RST) || (state_d == S_RUN) || (state_d == S_DONE);
        done_d    = (state_d == S_DONE);
    end

    // State, run results and control outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            rst_cnt     <= '0;
            cycle_count <= '0;
            status      <= ST_NONE;
            result_acc  <= '0;
            result_pc   <= '0;
            ready_q     <= 1'b1;
            cpu_rst     <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_d;
            rst_cnt     <= rst_cnt_d;
            cycle_count <= cycle_count_d;
            status      <= status_d;
            result_acc  <= result_acc_d;
            result_pc   <= result_pc_d;
            ready_q     <= ready_d;
            cpu_rst     <= cpu_rst_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

    // Instruction RAM write port: accepted beat is written on the next cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= accept;
            if (accept) begin
                imem_waddr <= load_addr;
                imem_wdata <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_cpu_run_controller.sv
module tb_cpu_run_controller;

    localparam int T = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [7:0] load_addr = '0;
    logic [7:0] load_data = '0;
    logic       load_last = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       cpu_halted;
    logic [7:0] cpu_acc;
    logic [7:0] cpu_pc;
    logic       cpu_rst;
    logic       imem_we;
    logic [7:0] imem_waddr;
    logic [7:0] imem_wdata;
    logic       busy;
    logic       done;
    logic [1:0] status;
    logic [7:0] result_acc;
    logic [7:0] result_pc;
    logic [15:0] cycle_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_run_controller #(
        .ADDR_W(8), .DATA_W(8), .RST_CYCLES(2), .TIMEOUT_CYCLES(T), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_addr(load_addr), .load_data(load_data), .load_last(load_last),
        .start(start), .abort(abort),
        .cpu_halted(cpu_halted), .cpu_acc(cpu_acc), .cpu_pc(cpu_pc),
        .cpu_rst(cpu_rst),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .status(status),
        .result_acc(result_acc), .result_pc(result_pc), .cycle_count(cycle_count)
    );

    // Instruction RAM fed only by the controller's write port.
    logic [7:0] ram [256] = '{default: 8'h00};
    always @(posedge clk) if (imem_we) ram[imem_waddr] <= imem_wdata;

    // Tiny accumulator CPU: Dx LDI, 5x STA, 4x LDA, 1x ADD, F0 HALT, else NOP.
    logic [7:0] c_pc = '0, c_acc = '0;
    logic       c_halt = 1'b0;
    logic [7:0] c_dm [16] = '{default: 8'h00};
    always @(posedge clk) begin
        if (cpu_rst) begin
            c_pc <= '0; c_acc <= '0; c_halt <= 1'b0;
            for (int i = 0; i < 16; i++) c_dm[i] <= '0;
        end else if (!c_halt) begin
            case (ram[c_pc][7:4])
                4'hD: begin c_acc <= {4'h0, ram[c_pc][3:0]}; c_pc <= c_pc + 8'd1; end
                4'h5: begin c_dm[ram[c_pc][3:0]] <= c_acc; c_pc <= c_pc + 8'd1; end
                4'h4: begin c_acc <= c_dm[ram[c_pc][3:0]]; c_pc <= c_pc + 8'd1; end
                4'h1: begin c_acc <= c_acc + c_dm[ram[c_pc][3:0]]; c_pc <= c_pc + 8'd1; end
                4'hF: c_halt <= 1'b1;
                default: c_pc <= c_pc + 8'd1;
            endcase
        end
    end
    assign cpu_halted = c_halt;
    assign cpu_acc    = c_acc;
    assign cpu_pc     = c_pc;

    // Bench's own record of the image it loaded.
    logic [7:0] img [256] = '{default: 8'h00};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Outcome from the run rules: halt > abort > timeout, one instruction per RUN cycle.
    task automatic predict(input int abort_at, output logic [1:0] st, output int cc,
                           output logic [7:0] acc, output logic [7:0] pc);
        logic [7:0] dm [16];
        logic h;
        logic [7:0] ins;
        bit fin;
        pc = 0; acc = 0; h = 0; fin = 0; st = 2'b00; cc = 0;
        for (int i = 0; i < 16; i++) dm[i] = 0;
        for (int c = 1; c <= T && !fin; c++) begin
            if (h) begin st = 2'b01; cc = c; fin = 1; end
            else if (c == abort_at) begin st = 2'b11; cc = c; fin = 1; end
            else if (c == T) begin st = 2'b10; cc = c; fin = 1; end
            else begin
                ins = img[pc];
                case (ins[7:4])
                    4'hD: begin acc = {4'h0, ins[3:0]}; pc++; end
                    4'h5: begin dm[ins[3:0]] = acc; pc++; end
                    4'h4: begin acc = dm[ins[3:0]]; pc++; end
                    4'h1: begin acc = acc + dm[ins[3:0]]; pc++; end
                    4'hF: h = 1;
                    default: pc++;
                endcase
            end
        end
    endtask

    // Stream an image; each write must appear one cycle after its beat.
    task automatic load_q(input logic [7:0] addrs[$], input logic [7:0] datas[$], input bit hold_start);
        int n = addrs.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("wr_we", int'(imem_we), 1);
                check("wr_addr", int'(imem_waddr), int'(addrs[i-1]));
                check("wr_data", int'(imem_wdata), int'(datas[i-1]));
            end
            check("load_ready", int'(load_ready), 1);
            load_valid = 1; load_addr = addrs[i]; load_data = datas[i];
            load_last = (i == n - 1); start = hold_start;
            img[addrs[i]] = datas[i];
        end
        @(negedge clk);
        check("wr_we_last", int'(imem_we), 1);
        check("wr_addr_last", int'(imem_waddr), int'(addrs[n-1]));
        load_valid = 0; load_last = 0; start = 0;
        @(negedge clk);
        check("wr_idle", int'(imem_we), 0);
        check("busy_after_load", int'(busy), 0);
    endtask

    // One run from IDLE; optionally offers load beats during RUN.
    task automatic run(input int abort_at, input bit poke, output logic [1:0] st,
                       output int cc, output logic [7:0] acc, output logic [7:0] pc);
        int k = 0, rstc = 0, t = 0;
        bit fin = 0;
        st = 0; cc = 0; acc = 0; pc = 0;
        @(negedge clk); start = 1;
        while (!fin && t < 400) begin
            @(negedge clk); t++; start = 0; abort = 0;
            if (done) begin
                fin = 1;
                check("rst_cycles", rstc, 2);
                check("done_busy", int'(busy), 1);
                check("done_cpu_rst", int'(cpu_rst), 1);
                if (poke) check("poke_no_write", int'(imem_we), 0);
                load_valid = 0;
                st = status; cc = int'(cycle_count); acc = result_acc; pc = result_pc;
            end else if (cpu_rst && busy) begin
                rstc++;
            end else if (!cpu_rst) begin
                k++;
                check("run_count", int'(cycle_count), k);
                if (poke) begin
                    check("poke_ready", int'(load_ready), 0);
                    check("poke_we", int'(imem_we), 0);
                    load_valid = 1; load_addr = 8'hFF; load_data = 8'h55;
                end
                if (k == abort_at) abort = 1;
            end
        end
        if (!fin) check("run_timeout", 0, 1);
        @(negedge clk);
        check("done_once", int'(done), 0);
        check("idle_busy", int'(busy), 0);
        check("idle_cpu_rst", int'(cpu_rst), 1);
        check("status_hold", int'(status), int'(st));
    endtask

    typedef struct {
        int         img_sel;   // 0 sum, 1 keep, 2 zeros 0..13, 3 HALT at 98
        int         abort_at;  // 0 = never
        bit         poke;
        logic [1:0] st;
        int         cc;
        logic [7:0] acc;
        logic [7:0] pc;
    } vec_t;

    logic [7:0] sum_prog [$] = '{8'hD5, 8'h51, 8'hD9, 8'h52, 8'hD4, 8'h53, 8'hD7,
                                 8'h54, 8'h41, 8'h12, 8'h13, 8'h14, 8'h50, 8'hF0};

    task automatic load_sel(input int sel);
        logic [7:0] a[$];
        logic [7:0] d[$];
        case (sel)
            0: for (int i = 0; i < 14; i++) begin a.push_back(8'(i)); d.push_back(sum_prog[i]); end
            2: for (int i = 0; i < 14; i++) begin a.push_back(8'(i)); d.push_back(8'h00); end
            3: begin a.push_back(8'd98); d.push_back(8'hF0); end
            default: ;
        endcase
        if (a.size() > 0) load_q(a, d, sel == 2);
    endtask

    initial begin
        vec_t vecs[4];
        logic [1:0] st, est;
        int cc, ecc, k, t;
        logic [7:0] acc, pc, eacc, epc;

        vecs[0] = '{0, 0, 1'b1, 2'b01, 15,  8'h19, 8'd13};
        vecs[1] = '{1, 5, 1'b0, 2'b11, 5,   8'h09, 8'd4};
        vecs[2] = '{2, 0, 1'b0, 2'b10, 100, 8'h00, 8'd99};
        vecs[3] = '{3, 0, 1'b0, 2'b01, 100, 8'h00, 8'd98};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_cpu_rst", int'(cpu_rst), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_status", int'(status), 0);
        check("rst_ready", int'(load_ready), 0);
        check("rst_we", int'(imem_we), 0);
        check("rst_count", int'(cycle_count), 0);
        reset = 1;
        @(negedge clk);
        check("idle_ready", int'(load_ready), 1);

        // Directed table.
        foreach (vecs[i]) begin
            load_sel(vecs[i].img_sel);
            run(vecs[i].abort_at, vecs[i].poke, st, cc, acc, pc);
            check($sformatf("vec%0d_status", i), int'(st), int'(vecs[i].st));
            check($sformatf("vec%0d_count", i), cc, vecs[i].cc);
            check($sformatf("vec%0d_acc", i), int'(acc), int'(vecs[i].acc));
            check($sformatf("vec%0d_pc", i), int'(pc), int'(vecs[i].pc));
        end

        // Reset in RUN cycle 4: silent abort, then a clean rerun.
        load_sel(0);
        @(negedge clk); start = 1;
        k = 0; t = 0;
        while (k < 4 && t < 50) begin
            @(negedge clk); t++; start = 0;
            if (!cpu_rst) k++;
        end
        check("mid_reset_reached", k, 4);
        reset = 0;
        @(negedge clk);
        check("mid_reset_cpu_rst", int'(cpu_rst), 1);
        check("mid_reset_busy", int'(busy), 0);
        check("mid_reset_done", int'(done), 0);
        check("mid_reset_status", int'(status), 0);
        check("mid_reset_count", int'(cycle_count), 0);
        check("mid_reset_ready", int'(load_ready), 0);
        reset = 1;
        @(negedge clk);
        check("post_reset_done", int'(done), 0);
        check("post_reset_ready", int'(load_ready), 1);
        run(0, 0, st, cc, acc, pc);
        check("rerun_status", int'(st), 1);
        check("rerun_acc", int'(acc), 8'h19);

        // start and load_valid together in IDLE: the byte wins.
        @(negedge clk);
        start = 1; load_valid = 1; load_addr = 8'hF0; load_data = 8'hAA; load_last = 1;
        img[8'hF0] = 8'hAA;
        @(negedge clk);
        start = 0; load_valid = 0; load_last = 0;
        check("tie_busy", int'(busy), 0);
        check("tie_we", int'(imem_we), 1);
        check("tie_addr", int'(imem_waddr), 8'hF0);
        check("tie_data", int'(imem_wdata), 8'hAA);
        @(negedge clk);
        check("tie_busy2", int'(busy), 0);
        check("tie_cpu_rst", int'(cpu_rst), 1);

        // Abort during RST clears results and reports aborted.
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        check("rst_abort_in_rst", int'(cpu_rst & busy), 1);
        abort = 1;
        @(negedge clk); abort = 0;
        check("rst_abort_done", int'(done), 1);
        check("rst_abort_status", int'(status), 3);
        check("rst_abort_acc", int'(result_acc), 0);
        check("rst_abort_pc", int'(result_pc), 0);
        check("rst_abort_count", int'(cycle_count), 0);
        @(negedge clk);
        check("rst_abort_idle", int'(busy), 0);

        // Random programs and abort points against the reference model.
        for (int r = 0; r < 20; r++) begin
            logic [7:0] a[$];
            logic [7:0] d[$];
            int len = $urandom_range(1, 24);
            int ab = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 40);
            for (int i = 0; i < len; i++) begin
                int sel = $urandom_range(0, 9);
                logic [3:0] x = 4'($urandom_range(0, 15));
                logic [7:0] b;
                case (sel)
                    4, 5: b = {4'hD, x};
                    6: b = {4'h5, x};
                    7: b = {4'h1, x};
                    8: b = {4'h4, x};
                    9: b = 8'hF0;
                    default: b = 8'h00;
                endcase
                a.push_back(8'(i)); d.push_back(b);
            end
            load_q(a, d, 1'($urandom_range(0, 1)));
            predict(ab, est, ecc, eacc, epc);
            run(ab, 0, st, cc, acc, pc);
            check($sformatf("rnd%0d_status", r), int'(st), int'(est));
            check($sformatf("rnd%0d_count", r), cc, ecc);
            check($sformatf("rnd%0d_acc", r), int'(acc), int'(eacc));
            check($sformatf("rnd%0d_pc", r), int'(pc), int'(epc));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
Sequencer that owns the accumulator CPU's execution lifecycle. It accepts a program image over a byte write interface into the instruction RAM and holds the CPU in reset while loading. On start it releases reset, watches for HALT or a cycle-budget timeout, captures ACC/PC and reports status. It sits between a host/test harness and the CPU plus instruction memory, replacing hand-driven reset and timeout logic.

Parameters:
ADDR_W, 8, instruction memory address width; matches CPU PC.
DATA_W, 8, instruction and ACC width.
RST_CYCLES, 2, number of cycles cpu_rst is held high before each run; must be ≥1.
TIMEOUT_CYCLES, 100, maximum RUN cycles before the run is declared timed out; must be ≥1.
CNT_W, 16, width of cycle_count; must be wide enough to hold TIMEOUT_CYCLES.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
load_valid  in  1  program byte offered
load_ready  out  1  controller accepts a byte this cycle
load_addr  in  ADDR_W  instruction RAM address
load_data  in  DATA_W  instruction byte
load_last  in  1  marks the final byte of the image
start  in  1  request a run (level, sampled per cycle)
abort  in  1  terminate the current run
cpu_halted  in  1  CPU halted flag
cpu_acc  in  DATA_W  CPU accumulator
cpu_pc  in  ADDR_W  CPU program counter
cpu_rst  out  1  active-high reset to the CPU
imem_we  out  1  instruction RAM write enable
imem_waddr  out  ADDR_W  instruction RAM write address
imem_wdata  out  DATA_W  instruction RAM write data
busy  out  1  high in RST, RUN and DONE
done  out  1  one-cycle pulse at run completion
status  out  2  00 none, 01 halted, 10 timeout, 11 aborted
result_acc  out  DATA_W  ACC captured at completion
result_pc  out  ADDR_W  PC captured at completion
cycle_count  out  CNT_W  RUN cycles elapsed in the current or last run

Behaviour:
- Reset (reset==0 at posedge clk) applies in any state: state=IDLE, cpu_rst=1, imem_we=0, load_ready=0, busy=0, done=0, status=00, result_acc=0, result_pc=0, cycle_count=0. A reset during RUN aborts silently; done is not pulsed.
- States are IDLE, LOAD, RST, RUN and DONE. cpu_rst=1 in every state except RUN. All outputs are registered.
- load_ready=1 in IDLE and LOAD only, and combinationally deasserted in any cycle in which reset is low.
- A beat is accepted when load_valid & load_ready. On the following cycle imem_we=1 with the captured addr/data (1-cycle latency). imem_we=0 otherwise. Back-to-back beats give back-to-back writes.
- IDLE transitions:
  - An accepted beat with load_last=0 goes to LOAD.
  - An accepted beat with load_last=1 stays in IDLE.
  - start=1 with load_valid=0 goes to RST, clears status, results and cycle_count, and loads the RST counter.
  - If start and load_valid are both high in the same cycle, the load wins and start is ignored.
- LOAD: start is ignored. An accepted beat with load_last=1 goes to IDLE. Write addresses are arbitrary; overwriting is allowed.
- RST: cpu_rst=1 for exactly RST_CYCLES cycles, then RUN. abort in RST goes to DONE with status=11 and result_acc/result_pc=0.
- RUN: cycle_count increments every cycle, starting from 1 on the first RUN cycle. Checks each cycle, highest priority first:
  1. cpu_halted=1: capture cpu_acc/cpu_pc, status=01, go to DONE.
  2. abort=1: capture, status=11, go to DONE.
  3. cycle_count==TIMEOUT_CYCLES: capture, status=10, go to DONE.
- A halt seen in the same cycle as the timeout threshold reports 01.
- DONE: lasts 1 cycle. done=1, cpu_rst=1 (re-asserted), then IDLE. status, result_acc, result_pc and cycle_count hold until the next accepted start or reset.
- Loads and start are refused while busy. load_valid in RST/RUN/DONE sees load_ready=0 and no write occurs. A new start is sampled only after returning to IDLE.

Test Plan:
1. Load the 14-byte sum program (D5 51 D9 52 D4 53 D7 54 41 12 13 14 50 F0 at addresses 0..13, load_last on byte 13) then pulse start -> 14 imem writes at the correct addresses; cpu_rst low after 2 cycles; done pulse; status=01; result_acc=0x19; result_pc = CPU PC at halt; cpu_rst=1 afterwards.
2. All-NOP image (no HALT), TIMEOUT_CYCLES=100, start -> done at RUN cycle 100; status=10; cycle_count=100.
3. Run the sum program and assert abort at RUN cycle 5 -> status=11; cycle_count=5; result_acc equals the live ACC at that cycle; done pulses once.
4. Drive reset low at RUN cycle 4 -> next cycle state=IDLE, cpu_rst=1, status=00, no done pulse. A restart then completes with status=01 and ACC=0x19.
5. Assert load_valid during RUN -> load_ready=0 and imem_we stays 0. Raise start and load_valid together in IDLE -> the byte is written, the run does not begin, and busy stays 0.
6. Set TIMEOUT_CYCLES equal to the HALT's RUN cycle for the sum program so halt and timeout coincide -> status=01.
